// File: rtl/apb_pwm_pkg.sv
// rtl/apb_pwm_pkg.sv - register map, CTRL/STATUS bit positions and PWM sequencer states
package apb_pwm_pkg;

  localparam logic [31:0] CTRL_A   = 32'h000;
  localparam logic [31:0] PERIOD_A = 32'h004;
  localparam logic [31:0] DUTY_A   = 32'h008;
  localparam logic [31:0] STATUS_A = 32'h00C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_FLAG = 0;
  localparam int STAT_RUN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/apb_pwm_ctrl_if.sv
// rtl/apb_pwm_ctrl_if.sv - APB register bus between the host and the PWM controller
interface apb_pwm_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - period counter, shadowed period/duty, IDLE/LOAD/RUN sequencer and output flop
module pwm_core
  import apb_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             pol_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o,
  output logic             period_end_o,
  output logic             running_o
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_q, pwm_d;
  logic             live;
  logic             wrap;
  logic             raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_LOAD;
      ST_LOAD: state_d = en_i ? ST_RUN : ST_IDLE;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with en_i drops the output and suppresses a pending wrap as soon as en is cleared.
  always_comb begin
    live         = (state_q == ST_RUN) && en_i;
    wrap         = live && (cnt_q == period_sh_q);
    raw          = live && (cnt_q < duty_sh_q);
    period_end_o = wrap;
    running_o    = (state_q == ST_RUN);
  end

  always_comb begin
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pwm_d       = raw ^ pol_i;
    case (state_q)
      ST_LOAD: begin
        cnt_d       = '0;
        period_sh_d = period_i;
        duty_sh_d   = duty_i;
      end
      ST_RUN: begin
        if (!en_i) begin
          cnt_d = '0;
        end else if (wrap) begin
          cnt_d       = '0;
          period_sh_d = period_i;
          duty_sh_d   = duty_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/apb_pwm_ctrl.sv
// rtl/apb_pwm_ctrl.sv - APB register block for the motor-drive PWM stage
module apb_pwm_ctrl
  import apb_pwm_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_pwm_ctrl_if.slave  apb,
  output logic           pwm_out,
  output logic           period_end,
  output logic           irq
);

  logic             en_q, en_d;
  logic             pol_q, pol_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             flag_q, flag_d;
  logic             running;

  logic [31:0] addr;
  logic        access, wr, rd;
  logic        sel_ctrl, sel_period, sel_duty, sel_status, hit;

  assign addr       = 32'(apb.PADDR[ADDR_W-1:0]);
  assign access     = apb.PSEL && apb.PENABLE;
  assign wr         = access && apb.PWRITE;
  assign rd         = access && !apb.PWRITE;
  assign sel_ctrl   = (addr == CTRL_A);
  assign sel_period = (addr == PERIOD_A);
  assign sel_duty   = (addr == DUTY_A);
  assign sel_status = (addr == STATUS_A);
  assign hit        = sel_ctrl || sel_period || sel_duty || sel_status;

  always_comb begin
    en_d     = en_q;
    pol_d    = pol_q;
    irq_en_d = irq_en_q;
    period_d = period_q;
    duty_d   = duty_q;
    flag_d   = flag_q;
    if (wr && sel_ctrl) begin
      en_d     = apb.PWDATA[CTRL_EN];
      pol_d    = apb.PWDATA[CTRL_POL];
      irq_en_d = apb.PWDATA[CTRL_IRQ_EN];
    end
    if (wr && sel_period) period_d = apb.PWDATA[CNT_W-1:0];
    if (wr && sel_duty)   duty_d   = apb.PWDATA[CNT_W-1:0];
    // A wrap in the same cycle as a W1C keeps the flag set.
    if (period_end) begin
      flag_d = 1'b1;
    end else if (wr && sel_status && apb.PWDATA[STAT_FLAG]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q     <= 1'b0;
      pol_q    <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      pol_q    <= pol_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (rd) begin
      if (sel_ctrl) begin
        apb.PRDATA[CTRL_EN]     = en_q;
        apb.PRDATA[CTRL_POL]    = pol_q;
        apb.PRDATA[CTRL_IRQ_EN] = irq_en_q;
      end
      if (sel_period) apb.PRDATA = 32'(period_q);
      if (sel_duty)   apb.PRDATA = 32'(duty_q);
      if (sel_status) begin
        apb.PRDATA[STAT_FLAG] = flag_q;
        apb.PRDATA[STAT_RUN]  = running;
      end
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access && !hit;
  assign irq         = flag_q && irq_en_q;

  pwm_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk          (PCLK),
    .rst          (PRESET),
    .en_i         (en_q),
    .pol_i        (pol_q),
    .period_i     (period_q),
    .duty_i       (duty_q),
    .pwm_o        (pwm_out),
    .period_end_o (period_end),
    .running_o    (running)
  );

endmodule

// File: tb/tb_apb_pwm_ctrl.sv
// tb/tb_apb_pwm_ctrl.sv - directed and randomized bench for apb_pwm_ctrl against a behavioural model
module tb_apb_pwm_ctrl;

  logic PCLK = 1'b0;
  logic PRESET;
  logic pwm_out, period_end, irq;

  apb_pwm_ctrl_if #(.ADDR_W(12)) bus ();

  apb_pwm_ctrl #(.CNT_W(16), .ADDR_W(12)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .apb        (bus),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .irq        (irq)
  );

  always #5 PCLK = ~PCLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: staged regs, active (shadow) period/duty and position within the period.
  int          m_phase;   // 0 stopped, 1 arming, 2 running
  bit          m_en, m_pol, m_irqen, m_flag, m_pwm;
  int unsigned m_period, m_duty, m_cur_p, m_cur_d, m_pos;

  task automatic model_reset();
    m_phase = 0; m_en = 0; m_pol = 0; m_irqen = 0; m_flag = 0; m_pwm = 0;
    m_period = 0; m_duty = 0; m_cur_p = 0; m_cur_d = 0; m_pos = 0;
  endtask

  task automatic model_step();
    bit acc, wr, live, wrap;
    int unsigned a;
    acc  = bus.PSEL && bus.PENABLE;
    wr   = acc && bus.PWRITE;
    a    = 32'(bus.PADDR);
    live = (m_phase == 2) && m_en;
    wrap = live && (m_pos == m_cur_p);
    m_pwm = (live && (m_pos < m_cur_d)) ^ m_pol;
    case (m_phase)
      0: begin m_pos = 0; if (m_en) m_phase = 1; end
      1: begin m_pos = 0; m_cur_p = m_period; m_cur_d = m_duty; m_phase = m_en ? 2 : 0; end
      default: begin
        if (!m_en) begin m_phase = 0; m_pos = 0; end
        else if (wrap) begin m_pos = 0; m_cur_p = m_period; m_cur_d = m_duty; end
        else m_pos++;
      end
    endcase
    if (wrap) m_flag = 1;
    else if (wr && a == 12 && bus.PWDATA[0]) m_flag = 0;
    if (wr) begin
      case (a)
        0: {m_irqen, m_pol, m_en} = bus.PWDATA[2:0];
        4: m_period = bus.PWDATA & 32'hFFFF;
        8: m_duty   = bus.PWDATA & 32'hFFFF;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_read(input int unsigned a);
    case (a)
      0:  return {29'b0, m_irqen, m_pol, m_en};
      4:  return m_period;
      8:  return m_duty;
      12: return {30'b0, (m_phase == 2), m_flag};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) model_reset();
    else model_step();
  end

  always @(negedge PCLK) begin
    if (chk_on) begin
      int unsigned a;
      bit acc, mapped;
      a      = 32'(bus.PADDR);
      acc    = bus.PSEL && bus.PENABLE;
      mapped = (a == 0) || (a == 4) || (a == 8) || (a == 12);
      check_eq("pwm_out", pwm_out, m_pwm);
      check_eq("period_end", period_end, (m_phase == 2) && m_en && (m_pos == m_cur_p));
      check_eq("irq", irq, m_flag && m_irqen);
      check_eq("pready", bus.PREADY, 1'b1);
      check_eq("pslverr", bus.PSLVERR, acc && !mapped);
      check_eq("prdata", bus.PRDATA, (acc && !bus.PWRITE) ? m_read(a) : 32'h0);
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    @(posedge PCLK); #1;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    #2;
    d = bus.PRDATA; err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  task automatic wait_pend();
    int k;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while (!period_end && k < 200);
    if (!period_end) check_eq("period_end_timeout", 32'h0, 32'h1);
  endtask

  task automatic count_win(input int n, output int highs, output int pends);
    highs = 0; pends = 0;
    repeat (n) begin
      @(negedge PCLK);
      highs += int'(pwm_out);
      pends += int'(period_end);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge PCLK); #3;
    PRESET = 1;
    #1;
    check_eq({tag, "_pwm"}, pwm_out, 1'b0);
    check_eq({tag, "_pend"}, period_end, 1'b0);
    check_eq({tag, "_irq"}, irq, 1'b0);
    @(posedge PCLK); #1;
    PRESET = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          hi, pe;
    logic [11:0] ra;

    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    PRESET = 1;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    chk_on = 1;

    for (int i = 0; i < 4; i++) begin
      apb_read(12'(4 * i), rd, err);
      check_eq("reset_read", rd, 32'h0);
      check_eq("reset_slverr", err, 1'b0);
    end
    apb_read(12'h010, rd, err);
    check_eq("unmapped_read", rd, 32'h0);
    check_eq("unmapped_slverr", err, 1'b1);

    apb_write(12'h004, 9);
    apb_write(12'h008, 3);
    apb_write(12'h000, 1);
    wait_pend();
    count_win(10, hi, pe);
    check_eq("duty3_highs", hi, 3);
    check_eq("duty3_pends", pe, 1);

    apb_write(12'h008, 7);
    wait_pend();
    count_win(10, hi, pe);
    check_eq("duty7_highs", hi, 7);

    apb_write(12'h008, 0);
    wait_pend(); wait_pend();
    count_win(10, hi, pe);
    check_eq("duty0_highs", hi, 0);

    apb_write(12'h008, 12);
    wait_pend(); wait_pend();
    count_win(10, hi, pe);
    check_eq("duty_gt_period_highs", hi, 10);

    apb_write(12'h004, 0);
    apb_write(12'h008, 1);
    wait_pend(); wait_pend();
    count_win(10, hi, pe);
    check_eq("period0_highs", hi, 10);
    check_eq("period0_pends", pe, 10);

    apb_write(12'h004, 9);
    apb_write(12'h008, 3);
    apb_write(12'h000, 0);
    apb_write(12'h00C, 1);
    apb_write(12'h000, 7);
    @(negedge PCLK);
    check_eq("irq_before_wrap", irq, 1'b0);
    wait_pend();
    @(negedge PCLK);
    check_eq("irq_after_wrap", irq, 1'b1);
    count_win(10, hi, pe);
    check_eq("inverted_highs", hi, 7);
    check_eq("inverted_pends", pe, 1);

    wait_pend();
    repeat (8) @(posedge PCLK);
    apb_write(12'h00C, 1);
    apb_read(12'h00C, rd, err);
    check_eq("w1c_on_wrap_status", rd, 32'h3);
    apb_write(12'h00C, 1);
    apb_read(12'h00C, rd, err);
    check_eq("w1c_clear_status", rd, 32'h2);
    @(negedge PCLK);
    check_eq("w1c_clear_irq", irq, 1'b0);

    apb_write(12'h000, 1);
    apb_write(12'h008, 12);
    wait_pend(); wait_pend();
    apb_write(12'h000, 0);
    @(negedge PCLK);
    check_eq("pwm_before_stop", pwm_out, 1'b1);
    @(negedge PCLK);
    check_eq("pwm_after_stop", pwm_out, 1'b0);
    apb_read(12'h00C, rd, err);
    check_eq("running_after_stop", rd & 32'h2, 32'h0);

    apb_write(12'h008, 3);
    apb_write(12'h000, 7);
    wait_pend();
    repeat (3) @(posedge PCLK);
    reset_pulse("preset_mid_run");
    apb_read(12'h000, rd, err);
    check_eq("ctrl_after_preset", rd, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1: apb_write(12'h000, 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0));
        2, 3: apb_write(12'h004, $urandom_range(0, 12));
        4, 5: apb_write(12'h008, $urandom_range(0, 14));
        6:    apb_write(12'h00C, $urandom);
        7: begin
          ra = ($urandom_range(0, 5) == 5) ? 12'($urandom) : 12'(4 * $urandom_range(0, 4));
          apb_read(ra, rd, err);
        end
        8: repeat ($urandom_range(1, 25)) @(posedge PCLK);
        default: begin
          if ($urandom_range(0, 19) == 0) reset_pulse("preset_random");
          else repeat (5) @(posedge PCLK);
        end
      endcase
    end

    repeat (20) @(posedge PCLK);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
